shot_sequencer: RTL and testbench

Top-level shot controller for the pool table. Sequences one shot per turn: aim, charge the cue power meter, fire, wait for the table to settle, then resolve turn ownership and fouls. Gates the power meter's charge input, latches the final power into a one-shot fire command for the ball physics, and tracks the current player. Sits between the keyboard decoder, the cue power meter and the ball motion/pocket logic, clocked by the VGA pixel clock.

---
 rtl/pool_pkg.sv | 18 +
 rtl/edge_detect.sv | 25 ++
 rtl/shot_sequencer.sv | 154 +++++++++++++++
 tb/tb_shot_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and default tuning constants for the pool table shot logic.
package pool_pkg;

    localparam int POWER_W           = 7;
    localparam int POWER_MIN_SHOT    = 4;
    localparam int MAX_CHARGE_FRAMES = 300;
    localparam int SETTLE_FRAMES     = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHARGE   = 3'd1,
        FIRE     = 3'd2,
        ROLLING  = 3'd3,
        RESOLVE  = 3'd4,
        GAMEOVER = 3'd5
    } shot_state_t;

endpackage

// File: rtl/edge_detect.sv
// Registered rise/fall pulse generator; each pulse lasts one clock and
// appears one clock after the input changes.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sigIn,
    output logic rise,
    output logic fall
);

    logic sigQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            sigQ <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sigQ <= sigIn;
            rise <= sigIn & ~sigQ;
            fall <= ~sigIn & sigQ;
        end
    end

endmodule

// File: rtl/shot_sequencer.sv
// Per-turn shot controller: aim, charge, fire, wait for the table to settle,
// then resolve turn ownership and scratch fouls.
module shot_sequencer #(
    parameter int POWER_W           = pool_pkg::POWER_W,
    parameter int POWER_MIN_SHOT    = pool_pkg::POWER_MIN_SHOT,
    parameter int MAX_CHARGE_FRAMES = pool_pkg::MAX_CHARGE_FRAMES,
    parameter int SETTLE_FRAMES     = pool_pkg::SETTLE_FRAMES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               spacePressed,
    input  logic [POWER_W-1:0] power,
    input  logic               ballsMoving,
    input  logic               ballPocketed,
    input  logic               cueBallPocketed,
    input  logic               gameOver,
    output logic               chargeEn,
    output logic               shotFire,
    output logic [POWER_W-1:0] shotPower,
    output logic               aimEnable,
    output logic               player,
    output logic               foul,
    output logic [2:0]         stateDbg
);

    import pool_pkg::*;

    localparam int CW = $clog2(MAX_CHARGE_FRAMES + 1);
    localparam int SW = $clog2(SETTLE_FRAMES + 1);
    localparam logic [CW-1:0]      CHARGE_LIMIT = CW'(MAX_CHARGE_FRAMES);
    localparam logic [SW-1:0]      SETTLE_LIMIT = SW'(SETTLE_FRAMES);
    localparam logic [POWER_W-1:0] MIN_POWER    = POWER_W'(POWER_MIN_SHOT);

    shot_state_t   state;
    shot_state_t   nextState;
    logic          frameTick;
    logic          frameFallUnused;
    logic          spaceRise;
    logic          spaceFall;
    logic          armed;
    logic          pocketFlag;
    logic          scratchFlag;
    logic [CW-1:0] chargeCnt;
    logic [SW-1:0] settleCnt;

    edge_detect frameEdge (
        .clk   (clk),
        .reset (reset),
        .sigIn (startOfFrame),
        .rise  (frameTick),
        .fall  (frameFallUnused)
    );

    edge_detect spaceEdge (
        .clk   (clk),
        .reset (reset),
        .sigIn (spacePressed),
        .rise  (spaceRise),
        .fall  (spaceFall)
    );

    // A timeout wins over a simultaneous low-power release, giving one fire.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (gameOver)
                    nextState = GAMEOVER;
                else if (armed && spaceRise)
                    nextState = CHARGE;
            end
            CHARGE: begin
                if (chargeCnt == CHARGE_LIMIT || (spaceFall && power >= MIN_POWER))
                    nextState = FIRE;
                else if (spaceFall)
                    nextState = IDLE;
            end
            FIRE:     nextState = ROLLING;
            ROLLING:  if (settleCnt == SETTLE_LIMIT) nextState = RESOLVE;
            RESOLVE:  nextState = gameOver ? GAMEOVER : IDLE;
            GAMEOVER: nextState = GAMEOVER;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            chargeCnt   <= '0;
            settleCnt   <= '0;
            pocketFlag  <= 1'b0;
            scratchFlag <= 1'b0;
            shotPower   <= '0;
            player      <= 1'b0;
            foul        <= 1'b0;
            shotFire    <= 1'b0;
            chargeEn    <= 1'b0;
            aimEnable   <= 1'b1;
        end else begin
            state     <= nextState;
            chargeEn  <= (nextState == CHARGE);
            shotFire  <= (nextState == FIRE);
            aimEnable <= (nextState == IDLE);

            // A key still held from the last shot must be released before it counts.
            if (state == IDLE && nextState == IDLE) begin
                if (!spacePressed)
                    armed <= 1'b1;
            end else begin
                armed <= 1'b0;
            end

            if (state == IDLE)
                chargeCnt <= '0;
            else if (state == CHARGE && frameTick && chargeCnt != CHARGE_LIMIT)
                chargeCnt <= chargeCnt + 1'b1;

            if (state == CHARGE && nextState == FIRE)
                shotPower <= power;

            if (state == ROLLING) begin
                if (ballsMoving)
                    settleCnt <= '0;
                else if (frameTick && settleCnt != SETTLE_LIMIT)
                    settleCnt <= settleCnt + 1'b1;
                pocketFlag  <= pocketFlag | ballPocketed;
                scratchFlag <= scratchFlag | cueBallPocketed;
            end else begin
                settleCnt <= '0;
                if (state == FIRE) begin
                    pocketFlag  <= 1'b0;
                    scratchFlag <= 1'b0;
                end
            end

            if (state == RESOLVE) begin
                if (scratchFlag) begin
                    foul   <= 1'b1;
                    player <= ~player;
                end else if (pocketFlag) begin
                    foul   <= 1'b0;
                end else begin
                    foul   <= 1'b0;
                    player <= ~player;
                end
            end
        end
    end

    assign stateDbg = state;

endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: random and directed shots checked every cycle
// against a phase-level model of the turn rules, plus literal spot checks.
module tb_shot_sequencer;

    localparam int PW     = 7;
    localparam int MINPWR = 4;
    localparam int MAXF   = 300;
    localparam int SETTLE = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          startOfFrame;
    logic          spacePressed;
    logic [PW-1:0] power;
    logic          ballsMoving;
    logic          ballPocketed;
    logic          cueBallPocketed;
    logic          gameOver;
    logic          chargeEn;
    logic          shotFire;
    logic [PW-1:0] shotPower;
    logic          aimEnable;
    logic          player;
    logic          foul;
    logic [2:0]    stateDbg;

    int nCompared   = 0;
    int nMismatched = 0;

    shot_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .spacePressed    (spacePressed),
        .power           (power),
        .ballsMoving     (ballsMoving),
        .ballPocketed    (ballPocketed),
        .cueBallPocketed (cueBallPocketed),
        .gameOver        (gameOver),
        .chargeEn        (chargeEn),
        .shotFire        (shotFire),
        .shotPower       (shotPower),
        .aimEnable       (aimEnable),
        .player          (player),
        .foul            (foul),
        .stateDbg        (stateDbg)
    );

    always #5 clk = ~clk;

    initial begin
        #(8_000_000);
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- reference model ----------------
    string phase = "idle";
    bit    modelValid = 0;
    bit    mTick, mRise, mFall, sofPrev, spPrev, mArmed;
    bit    pocketSeen, scratchSeen, mPlayer, mFoul;
    int    framesCharged, quietFrames, mPower;
    logic [PW-1:0] exp_q[$];

    task automatic modelStep();
        bit tick, rise, fall;
        tick = mTick;
        rise = mRise;
        fall = mFall;
        if (reset) begin
            {mTick, mRise, mFall, sofPrev, spPrev, mArmed} = '0;
            {pocketSeen, scratchSeen, mPlayer, mFoul} = '0;
            framesCharged = 0;
            quietFrames = 0;
            mPower = 0;
            phase = "idle";
            exp_q.delete();
            modelValid = 1;
            return;
        end
        mTick = startOfFrame && !sofPrev;
        sofPrev = startOfFrame;
        mRise = spacePressed && !spPrev;
        mFall = !spacePressed && spPrev;
        spPrev = spacePressed;

        if (phase == "idle") begin
            if (gameOver) phase = "over";
            else if (mArmed && rise) begin
                phase = "charge";
                mArmed = 0;
                framesCharged = 0;
            end else if (!spacePressed) mArmed = 1;
        end else if (phase == "charge") begin
            if (framesCharged >= MAXF || (fall && int'(power) >= MINPWR)) begin
                mPower = int'(power);
                exp_q.push_back(power);
                phase = "fire";
            end else if (fall) phase = "idle";
            else if (tick) framesCharged++;
        end else if (phase == "fire") begin
            phase = "roll";
            quietFrames = 0;
            pocketSeen = 0;
            scratchSeen = 0;
        end else if (phase == "roll") begin
            if (quietFrames >= SETTLE) phase = "resolve";
            pocketSeen  = pocketSeen | ballPocketed;
            scratchSeen = scratchSeen | cueBallPocketed;
            if (ballsMoving) quietFrames = 0;
            else if (tick && quietFrames < SETTLE) quietFrames++;
        end else if (phase == "resolve") begin
            // Turn passes unless an object ball dropped without a scratch.
            mFoul = scratchSeen;
            if (scratchSeen || !pocketSeen) mPlayer = !mPlayer;
            phase = gameOver ? "over" : "idle";
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (modelValid) begin
            check("chargeEn", chargeEn, phase == "charge");
            check("shotFire", shotFire, phase == "fire");
            check("aimEnable", aimEnable, phase == "idle");
            check("shotPower", shotPower, mPower);
            check("player", player, mPlayer);
            check("foul", foul, mFoul);
            check("idle_dbg", stateDbg == 3'd0, phase == "idle");
            if (shotFire === 1'b1) begin
                check("fire_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("fire_power_sb", shotPower, exp_q.pop_front());
            end
        end
    end

    // ---------------- frame source ----------------
    initial begin
        startOfFrame = 1'b0;
        step(3);
        forever begin
            startOfFrame = 1'b1;
            step($urandom_range(1, 2));
            startOfFrame = 1'b0;
            step($urandom_range(10, 18));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic waitFrames(input int n);
        int seen = 0;
        logic prev = startOfFrame;
        for (int i = 0; i < n * 40 && seen < n; i++) begin
            step(1);
            if (startOfFrame && !prev) seen++;
            prev = startOfFrame;
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 3000 && stateDbg != 3'd0; i++) step(1);
        check("idle_reached", stateDbg, 0);
    endtask

    task automatic waitCharge(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (chargeEn === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("charge_entered", chargeEn, 1);
    endtask

    task automatic countFires(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            step(1);
            if (shotFire === 1'b1) n++;
        end
    endtask

    task automatic pulse(input bit scratch);
        if (scratch) cueBallPocketed = 1'b1;
        else ballPocketed = 1'b1;
        step(1);
        cueBallPocketed = 1'b0;
        ballPocketed = 1'b0;
    endtask

    task automatic doShot(input int pwr, input int moveFrames, input int pocketAt, input int scratchAt);
        int n, lat;
        waitIdle();
        spacePressed = 1'b0;
        step(2);
        power = PW'(pwr);
        spacePressed = 1'b1;
        waitCharge(lat);
        waitFrames(1);
        spacePressed = 1'b0;
        countFires(4, n);
        if (n == 0) return;
        if (moveFrames > 0) ballsMoving = 1'b1;
        for (int f = 0; f < moveFrames; f++) begin
            if (f == pocketAt) pulse(0);
            if (f == scratchAt) pulse(1);
            waitFrames(1);
        end
        ballsMoving = 1'b0;
        waitIdle();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_chargeEn"}, chargeEn, 0);
        check({tag, "_shotFire"}, shotFire, 0);
        check({tag, "_aimEnable"}, aimEnable, 1);
        check({tag, "_shotPower"}, shotPower, 0);
        check({tag, "_player"}, player, 0);
        check({tag, "_foul"}, foul, 0);
        check({tag, "_state"}, stateDbg, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, n, pwr, frames;
        logic prev;
        reset = 1'b1;
        spacePressed = 1'b1;
        power = '0;
        ballsMoving = 1'b0;
        ballPocketed = 1'b0;
        cueBallPocketed = 1'b0;
        gameOver = 1'b0;
        step(4);
        checkResetOutputs("por");
        reset = 1'b0;
        step(6);
        check("held_key_no_charge", chargeEn, 0);

        // Basic shot: press latency, release fires once with the held power.
        spacePressed = 1'b0;
        step(3);
        power = 7'd60;
        spacePressed = 1'b1;
        waitCharge(lat);
        check("charge_latency", lat, 2);
        waitFrames(2);
        spacePressed = 1'b0;
        lat = 0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (shotFire === 1'b1) begin
                n++;
                if (lat == 0) lat = i;
            end
        end
        check("fire_latency", lat, 2);
        check("fire_count", n, 1);
        check("fire_power", shotPower, 60);
        waitIdle();
        check("miss_player", player, 1);
        check("miss_foul", foul, 0);

        // Weak release cancels.
        step(2);
        power = 7'd3;
        spacePressed = 1'b1;
        waitCharge(lat);
        waitFrames(1);
        spacePressed = 1'b0;
        countFires(10, n);
        check("cancel_no_fire", n, 0);
        check("cancel_idle", stateDbg, 0);
        check("cancel_player", player, 1);
        check("cancel_power_hold", shotPower, 60);

        // Held key times out into an automatic fire.
        step(2);
        pwr = $urandom_range(10, 127);
        power = PW'(pwr);
        spacePressed = 1'b1;
        waitCharge(lat);
        frames = 0;
        n = 0;
        prev = startOfFrame;
        for (int i = 0; i < 9000; i++) begin
            step(1);
            if (startOfFrame && !prev && chargeEn) frames++;
            prev = startOfFrame;
            if (shotFire === 1'b1) begin
                n = 1;
                break;
            end
        end
        check("autofire_seen", n, 1);
        check("autofire_frames", frames >= MAXF - 1 && frames <= MAXF + 1, 1);
        check("autofire_power", shotPower, pwr);
        ballsMoving = 1'b1;
        waitFrames(3);
        ballsMoving = 1'b0;
        waitIdle();
        countFires(60, n);
        check("held_no_refire", n, 0);
        check("held_no_rearm", chargeEn, 0);
        spacePressed = 1'b0;
        countFires(20, n);
        check("late_release_ignored", n, 0);
        check("autofire_player", player, 0);

        // Object ball pocketed mid-roll keeps the turn.
        doShot(50, 40, 20, -1);
        check("pocket_player", player, 0);
        check("pocket_foul", foul, 0);

        // Scratch hands over the turn with a foul; next miss clears it.
        doShot(70, 3, -1, 1);
        check("scratch_foul", foul, 1);
        check("scratch_player", player, 1);
        doShot(25, 2, -1, -1);
        check("after_scratch_foul", foul, 0);
        check("after_scratch_player", player, 0);

        // Randomised shots, including cancels and stray pocket pulses.
        for (int s = 0; s < 12; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                waitIdle();
                pulse($urandom_range(0, 1) == 1);
            end
            pwr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 127);
            doShot(pwr, $urandom_range(0, 6), $urandom_range(0, 6) - 1, $urandom_range(0, 10) - 3);
        end

        // Reset while charging.
        waitIdle();
        spacePressed = 1'b0;
        step(2);
        power = 7'd90;
        spacePressed = 1'b1;
        waitCharge(lat);
        waitFrames(1);
        reset = 1'b1;
        step(1);
        checkResetOutputs("rst_charge");
        reset = 1'b0;
        step(3);
        spacePressed = 1'b0;
        countFires(10, n);
        check("rst_charge_no_fire", n, 0);

        // Reset while rolling.
        power = 7'd40;
        spacePressed = 1'b1;
        waitCharge(lat);
        spacePressed = 1'b0;
        countFires(4, n);
        check("roll_fired", n, 1);
        ballsMoving = 1'b1;
        waitFrames(2);
        reset = 1'b1;
        step(1);
        checkResetOutputs("rst_roll");
        reset = 1'b0;
        ballsMoving = 1'b0;
        countFires(20, n);
        check("rst_roll_no_fire", n, 0);

        // Game over is sticky until reset.
        waitIdle();
        step(2);
        gameOver = 1'b1;
        step(3);
        check("gameover_entered", stateDbg != 3'd0, 1);
        check("gameover_aim_off", aimEnable, 0);
        gameOver = 1'b0;
        spacePressed = 1'b1;
        step(10);
        spacePressed = 1'b0;
        countFires(40, n);
        check("gameover_no_fire", n, 0);
        check("gameover_persists", stateDbg != 3'd0, 1);
        check("gameover_no_charge", chargeEn, 0);
        reset = 1'b1;
        step(1);
        checkResetOutputs("rst_gameover");
        reset = 1'b0;
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
